// File: rtl/ar_fifo_push_ctrl_if.sv
// AR-channel handshake and AR async-FIFO write port bundle.
// slave is the push controller side, master is the interconnect/FIFO side.
interface ar_fifo_push_ctrl_if;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S;
    logic        ARREADY_S;
    logic        fifo_wpush;
    logic [48:0] fifo_wdata;
    logic        fifo_wfull;

    modport slave (
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, fifo_wfull,
        output ARREADY_S, fifo_wpush, fifo_wdata
    );

    modport master (
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, fifo_wfull,
        input  ARREADY_S, fifo_wpush, fifo_wdata
    );
endinterface

// File: rtl/ar_fifo_push_ctrl.sv
// AR write-side front end: 2-entry skid buffer feeding the AR async FIFO,
// with an outstanding-read cap retired by the R-path done pulse.
module ar_fifo_push_ctrl #(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 3
) (
    input  logic                 wclk,
    input  logic                 wrst,
    ar_fifo_push_ctrl_if.slave   ar,
    input  logic                 r_done,
    output logic [CNT_W-1:0]     outst_cnt,
    output logic                 underflow
);

    generate
        if (MAX_OUTST < 1 || MAX_OUTST > 7 || (1 << CNT_W) <= MAX_OUTST) begin : g_bad_param
            $error("ar_fifo_push_ctrl: MAX_OUTST must be 1..7 and fit below 2**CNT_W");
        end
    endgenerate

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_req_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_st_t;

    buf_st_t st, st_nxt;
    ar_req_t mem [2];
    ar_req_t req_in;
    logic    head, tail;
    logic    buf_nempty, buf_full;
    logic    hs, push, ar_ready;

    assign req_in = '{id: ar.ARID_S, addr: ar.ARADDR_S, len: ar.ARLEN_S,
                      size: ar.ARSIZE_S, burst: ar.ARBURST_S};

    // Ready depends only on registered occupancy/count (and reset), never on ARVALID_S or fifo_wfull.
    assign ar_ready = ~wrst & ~buf_full & (outst_cnt < CNT_W'(MAX_OUTST));
    assign hs       = ar.ARVALID_S & ar_ready;
    assign push     = buf_nempty & ~ar.fifo_wfull;

    assign ar.ARREADY_S  = ar_ready;
    assign ar.fifo_wpush = push;
    assign ar.fifo_wdata = buf_nempty ? mem[head] : '0;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            st   <= BUF_EMPTY;
            head <= 1'b0;
            tail <= 1'b0;
        end else begin
            st <= st_nxt;
            if (hs)   tail <= ~tail;
            if (push) head <= ~head;
        end
    end

    always_ff @(posedge wclk) begin
        if (hs) mem[tail] <= req_in;
    end

    always_comb begin
        st_nxt     = st;
        buf_nempty = 1'b0;
        buf_full   = 1'b0;
        case (st)
            BUF_EMPTY: begin
                if (hs) st_nxt = BUF_ONE;
            end
            BUF_ONE: begin
                buf_nempty = 1'b1;
                if (hs && !push)      st_nxt = BUF_TWO;
                else if (!hs && push) st_nxt = BUF_EMPTY;
            end
            BUF_TWO: begin
                buf_nempty = 1'b1;
                buf_full   = 1'b1;
                if (push) st_nxt = BUF_ONE;
            end
            default: st_nxt = BUF_EMPTY;
        endcase
    end

    // Handshake and retire in one cycle cancel; a stray retire at zero latches the error.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            outst_cnt <= '0;
            underflow <= 1'b0;
        end else begin
            case ({hs, r_done})
                2'b10: outst_cnt <= outst_cnt + CNT_W'(1);
                2'b01: begin
                    if (outst_cnt == '0) underflow <= 1'b1;
                    else                 outst_cnt <= outst_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ar_fifo_push_ctrl.sv
// Bench for ar_fifo_push_ctrl: directed scenarios plus a randomized run,
// all checked against a queue-based model of the buffer and in-flight count.
module tb_ar_fifo_push_ctrl;
    localparam int MAX   = 4;
    localparam int CNT_W = 3;

    logic             wclk = 1'b0;
    logic             wrst;
    logic             r_done;
    logic [CNT_W-1:0] outst_cnt;
    logic             underflow;

    ar_fifo_push_ctrl_if ar_if ();

    ar_fifo_push_ctrl #(.MAX_OUTST(MAX), .CNT_W(CNT_W)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .ar        (ar_if),
        .r_done    (r_done),
        .outst_cnt (outst_cnt),
        .underflow (underflow)
    );

    always #5 wclk = ~wclk;

    int errors = 0;
    int checks = 0;

    // Reference model: requests accepted but not yet pushed, reads in flight, sticky error.
    logic [48:0] mq[$];
    int          mcnt;
    bit          munder;

    function automatic logic [48:0] pack(input logic [7:0] id, input logic [31:0] addr,
                                         input logic [3:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
        return {id, addr, len, size, burst};
    endfunction

    function automatic bit m_ready();
        return !wrst && mq.size() < 2 && mcnt < MAX;
    endfunction

    function automatic bit m_push();
        return mq.size() > 0 && !ar_if.fifo_wfull;
    endfunction

    function automatic logic [48:0] m_wdata();
        return (mq.size() > 0) ? mq[0] : 49'd0;
    endfunction

    function automatic logic [48:0] cur_word();
        return pack(ar_if.ARID_S, ar_if.ARADDR_S, ar_if.ARLEN_S, ar_if.ARSIZE_S, ar_if.ARBURST_S);
    endfunction

    // Advance one clock, applying the spec's rules to the model with the inputs held this cycle.
    task automatic tick();
        bit          hs, pu;
        logic [48:0] w;
        hs = ar_if.ARVALID_S && m_ready();
        pu = m_push();
        w  = cur_word();
        @(posedge wclk);
        if (wrst) begin
            mq.delete();
            mcnt   = 0;
            munder = 0;
        end else begin
            if (pu) void'(mq.pop_front());
            if (hs) mq.push_back(w);
            if (hs && !r_done)       mcnt++;
            else if (!hs && r_done) begin
                if (mcnt == 0) munder = 1;
                else           mcnt--;
            end
        end
        #1;
    endtask

    task automatic set_req(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        ar_if.ARID_S    = id;
        ar_if.ARADDR_S  = addr;
        ar_if.ARLEN_S   = len;
        ar_if.ARSIZE_S  = size;
        ar_if.ARBURST_S = burst;
    endtask

    task automatic rand_req();
        set_req(8'($urandom), $urandom, 4'($urandom), 3'($urandom), 2'($urandom));
    endtask

    task automatic retire_all();
        ar_if.ARVALID_S  = 1'b0;
        ar_if.fifo_wfull = 1'b0;
        while (mcnt > 0) begin
            r_done = 1'b1;
            tick();
        end
        r_done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        wrst = 1'b1;
        ar_if.ARVALID_S  = 1'b1;
        ar_if.fifo_wfull = 1'b0;
        r_done = 1'b0;
        rand_req();
        tick();
        tick();
        @(negedge wclk);
        checks++; if (ar_if.ARREADY_S !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", ar_if.ARREADY_S); end
        checks++; if (ar_if.fifo_wpush !== 1'b0) begin errors++; $display("FAIL reset_wpush: got %b exp 0", ar_if.fifo_wpush); end
        checks++; if (ar_if.fifo_wdata !== 49'd0) begin errors++; $display("FAIL reset_wdata: got %h exp 0", ar_if.fifo_wdata); end
        checks++; if (outst_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", outst_cnt); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b exp 0", underflow); end
        tick();
        wrst = 1'b0;
        ar_if.ARVALID_S = 1'b0;
        @(negedge wclk);
        checks++; if (ar_if.ARREADY_S !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b exp 1", ar_if.ARREADY_S); end
        tick();
    endtask

    task automatic test_single();
        logic [48:0] exp_w;
        set_req(8'h12, 32'h0001_0040, 4'd3, 3'd2, 2'd1);
        exp_w = pack(8'h12, 32'h0001_0040, 4'd3, 3'd2, 2'd1);
        ar_if.ARVALID_S = 1'b1;
        @(negedge wclk);
        checks++; if (ar_if.fifo_wpush !== 1'b0) begin errors++; $display("FAIL single_early_push: got %b exp 0", ar_if.fifo_wpush); end
        tick();
        ar_if.ARVALID_S = 1'b0;
        @(negedge wclk);
        checks++; if (ar_if.fifo_wpush !== 1'b1) begin errors++; $display("FAIL single_push: got %b exp 1", ar_if.fifo_wpush); end
        checks++; if (ar_if.fifo_wdata !== exp_w) begin errors++; $display("FAIL single_wdata: got %h exp %h", ar_if.fifo_wdata, exp_w); end
        checks++; if (outst_cnt !== 3'd1) begin errors++; $display("FAIL single_cnt: got %0d exp 1", outst_cnt); end
        tick();
        @(negedge wclk);
        checks++; if (ar_if.fifo_wpush !== 1'b0) begin errors++; $display("FAIL single_no_repush: got %b exp 0", ar_if.fifo_wpush); end
        retire_all();
    endtask

    task automatic test_backpressure();
        logic [48:0] w [3];
        ar_if.fifo_wfull = 1'b1;
        ar_if.ARVALID_S  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_req();
            w[i] = cur_word();
            @(negedge wclk);
            checks++; if (ar_if.ARREADY_S !== (i < 2)) begin errors++; $display("FAIL bp_ready%0d: got %b exp %b", i, ar_if.ARREADY_S, (i < 2)); end
            checks++; if (ar_if.fifo_wpush !== 1'b0) begin errors++; $display("FAIL bp_nopush%0d: got %b exp 0", i, ar_if.fifo_wpush); end
            tick();
        end
        ar_if.fifo_wfull = 1'b0;
        @(negedge wclk);
        checks++; if (ar_if.ARREADY_S !== 1'b0) begin errors++; $display("FAIL bp_still_full: got %b exp 0", ar_if.ARREADY_S); end
        checks++; if (ar_if.fifo_wpush !== 1'b1 || ar_if.fifo_wdata !== w[0]) begin errors++; $display("FAIL bp_push0: got %b/%h exp 1/%h", ar_if.fifo_wpush, ar_if.fifo_wdata, w[0]); end
        tick();
        @(negedge wclk);
        checks++; if (ar_if.fifo_wpush !== 1'b1 || ar_if.fifo_wdata !== w[1]) begin errors++; $display("FAIL bp_push1: got %b/%h exp 1/%h", ar_if.fifo_wpush, ar_if.fifo_wdata, w[1]); end
        checks++; if (ar_if.ARREADY_S !== 1'b1) begin errors++; $display("FAIL bp_third_ready: got %b exp 1", ar_if.ARREADY_S); end
        tick();
        ar_if.ARVALID_S = 1'b0;
        @(negedge wclk);
        checks++; if (ar_if.fifo_wpush !== 1'b1 || ar_if.fifo_wdata !== w[2]) begin errors++; $display("FAIL bp_push2: got %b/%h exp 1/%h", ar_if.fifo_wpush, ar_if.fifo_wdata, w[2]); end
        checks++; if (outst_cnt !== 3'd3) begin errors++; $display("FAIL bp_cnt: got %0d exp 3", outst_cnt); end
        tick();
        retire_all();
    endtask

    task automatic test_outst_cap();
        ar_if.fifo_wfull = 1'b0;
        ar_if.ARVALID_S  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_req();
            @(negedge wclk);
            checks++; if (ar_if.ARREADY_S !== (i < MAX)) begin errors++; $display("FAIL cap_ready%0d: got %b exp %b", i, ar_if.ARREADY_S, (i < MAX)); end
            if (i < MAX) tick();
        end
        checks++; if (outst_cnt !== 3'd4) begin errors++; $display("FAIL cap_cnt: got %0d exp 4", outst_cnt); end
        r_done = 1'b1;
        tick();
        r_done = 1'b0;
        @(negedge wclk);
        checks++; if (outst_cnt !== 3'd3) begin errors++; $display("FAIL cap_retire_cnt: got %0d exp 3", outst_cnt); end
        checks++; if (ar_if.ARREADY_S !== 1'b1) begin errors++; $display("FAIL cap_reopen: got %b exp 1", ar_if.ARREADY_S); end
        tick();
        ar_if.ARVALID_S = 1'b0;
        @(negedge wclk);
        checks++; if (outst_cnt !== 3'd4) begin errors++; $display("FAIL cap_fifth_cnt: got %0d exp 4", outst_cnt); end
        checks++; if (ar_if.fifo_wdata !== m_wdata()) begin errors++; $display("FAIL cap_fifth_data: got %h exp %h", ar_if.fifo_wdata, m_wdata()); end
        tick();
        retire_all();
    endtask

    task automatic test_simultaneous();
        ar_if.ARVALID_S = 1'b1;
        rand_req(); tick();
        rand_req(); tick();
        ar_if.ARVALID_S = 1'b0;
        tick();
        rand_req();
        ar_if.ARVALID_S = 1'b1;
        r_done = 1'b1;
        @(negedge wclk);
        checks++; if (outst_cnt !== 3'd2 || ar_if.ARREADY_S !== 1'b1) begin errors++; $display("FAIL simul_pre: got cnt %0d rdy %b exp 2/1", outst_cnt, ar_if.ARREADY_S); end
        tick();
        ar_if.ARVALID_S = 1'b0;
        r_done = 1'b0;
        @(negedge wclk);
        checks++; if (outst_cnt !== 3'd2) begin errors++; $display("FAIL simul_cnt: got %0d exp 2", outst_cnt); end
        checks++; if (ar_if.fifo_wpush !== 1'b1 || ar_if.fifo_wdata !== m_wdata()) begin errors++; $display("FAIL simul_push: got %b/%h exp 1/%h", ar_if.fifo_wpush, ar_if.fifo_wdata, m_wdata()); end
        tick();
        retire_all();
    endtask

    task automatic test_underflow();
        r_done = 1'b1;
        tick();
        r_done = 1'b0;
        @(negedge wclk);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b exp 1", underflow); end
        checks++; if (outst_cnt !== 3'd0) begin errors++; $display("FAIL uf_cnt: got %0d exp 0", outst_cnt); end
        tick(); tick();
        @(negedge wclk);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_hold: got %b exp 1", underflow); end
        wrst = 1'b1;
        tick();
        wrst = 1'b0;
        @(negedge wclk);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b exp 0", underflow); end
        tick();
    endtask

    task automatic test_reset_midop();
        ar_if.fifo_wfull = 1'b1;
        ar_if.ARVALID_S  = 1'b1;
        rand_req(); tick();
        rand_req(); tick();
        ar_if.ARVALID_S = 1'b0;
        wrst = 1'b1;
        @(negedge wclk);
        checks++; if (ar_if.ARREADY_S !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b exp 0", ar_if.ARREADY_S); end
        tick();
        wrst = 1'b0;
        ar_if.fifo_wfull = 1'b0;
        @(negedge wclk);
        checks++; if (ar_if.fifo_wpush !== 1'b0) begin errors++; $display("FAIL mid_no_push: got %b exp 0", ar_if.fifo_wpush); end
        checks++; if (outst_cnt !== 3'd0) begin errors++; $display("FAIL mid_cnt: got %0d exp 0", outst_cnt); end
        checks++; if (ar_if.ARREADY_S !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b exp 1", ar_if.ARREADY_S); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            ar_if.ARVALID_S  = ($urandom_range(99) < 70);
            ar_if.fifo_wfull = ($urandom_range(99) < 30);
            r_done           = (mcnt > 0) && ($urandom_range(99) < 25);
            if (ar_if.ARVALID_S && !(m_ready())) begin end else rand_req();
            @(negedge wclk);
            checks++; if (ar_if.ARREADY_S !== m_ready()) begin errors++; $display("FAIL rnd_ready@%0d: got %b exp %b", c, ar_if.ARREADY_S, m_ready()); end
            checks++; if (ar_if.fifo_wpush !== m_push()) begin errors++; $display("FAIL rnd_push@%0d: got %b exp %b", c, ar_if.fifo_wpush, m_push()); end
            checks++; if (ar_if.fifo_wdata !== m_wdata()) begin errors++; $display("FAIL rnd_wdata@%0d: got %h exp %h", c, ar_if.fifo_wdata, m_wdata()); end
            checks++; if (outst_cnt !== CNT_W'(mcnt)) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d exp %0d", c, outst_cnt, mcnt); end
            checks++; if (underflow !== munder) begin errors++; $display("FAIL rnd_underflow@%0d: got %b exp %b", c, underflow, munder); end
            tick();
        end
        retire_all();
    endtask

    initial begin
        wrst   = 1'b1;
        r_done = 1'b0;
        mcnt   = 0;
        munder = 0;
        ar_if.ARVALID_S  = 1'b0;
        ar_if.fifo_wfull = 1'b0;
        set_req('0, '0, '0, '0, '0);
        test_reset();
        test_single();
        test_backpressure();
        test_outst_cap();
        test_simultaneous();
        test_underflow();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
